syn_byte_packer: RTL and testbench
==================================

# syn_byte_packer

Downstream stage of the synthesis top: consumes the registered 8-bit result stream and its qualifier (`c_output`/`d_output`) and packs consecutive valid bytes into `C_WORD_W`-bit words. Completed words are buffered in a small first-word-fall-through FIFO and presented on a valid/ready interface toward the bus side. The upstream stage has no backpressure, so overflow is detected and flagged here rather than pushed back.

## Interface
- `C_WORD_W`, 32: output word width; multiple of 8, at least 16. Lanes N = `C_WORD_W`/8.
- `C_FIFO_DEPTH`, 4: word FIFO depth; power of 2, at least 2.
- `clk`  in  1  single clock, rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `byte_data`  in  8  byte from upstream (`c_output`).
- `byte_vld`  in  1  byte qualifier (`d_output`); a byte is taken on every edge where it is high.
- `word_data`  out  `C_WORD_W`  packed word; byte k in bits [8k+7:8k], first-received byte in lane 0.
- `word_vld`  out  1  word available.
- `word_rdy`  in  1  consumer accepts when `word_vld & word_rdy`.
- `fifo_level`  out  clog2(`C_FIFO_DEPTH`)+1  words currently stored.
- `ovf_clr`  in  1  clears the sticky overflow flag.
- `overflow`  out  1  sticky: a completed word was dropped.
- `flush`, `word_bytes` (`SYN_PACKER_FLUSH_EN` only): see Configuration.

## Operation
- Lane counter 0..N-1, assembly register N-1 bytes wide. Each accepted byte is written to the current lane, and the counter increments.
- On the Nth byte, the assembled word (N-1 held bytes plus the current byte) is pushed into the FIFO, and the counter wraps to 0 on the same edge.
- Push with FIFO full and no pop on that edge: the word is dropped, `overflow` is set, and the counter still wraps. Push and pop on the same edge while full: both take effect, and no overflow occurs.
- `ovf_clr` clears `overflow`. If it coincides with a new overflow event, set wins.
- Output: `word_data` is the FIFO head and is held stable while `word_vld & ~word_rdy`. `word_rdy` while `word_vld` is low has no effect.
- Reset, including mid-word or mid-burst: `word_vld`=0, `word_data`=0, `fifo_level`=0, `overflow`=0, lane counter=0, `word_bytes`=0. Partial bytes and stored words are discarded.

## Timing
- Word completion on edge T: `word_vld`=1 and `fifo_level` incremented in the cycle after T, provided the FIFO was empty. The write-to-read latency is 1 cycle.
- The packer sustains one byte per cycle, so there is at most one word every N cycles. A consumer holding `word_rdy`=1 never causes overflow.
- `fifo_level` reflects pushes and pops registered on the previous edge.
- `overflow` rises in the cycle after the dropping edge.

## Configuration
- `SYN_PACKER_FLUSH_EN` defined: adds the following.
  - Input `flush` (1).
  - Output `word_bytes` (clog2(N)+1), which travels with each FIFO entry.
  - On an edge with `flush`=1 and a nonzero count (including a byte taken on the same edge), the partial word is pushed with unfilled lanes zero and `word_bytes` set to the filled-lane count. The counter then returns to 0.
  - `flush` with a count of 0 and no byte is a no-op.
  - Full words carry `word_bytes`=N.
  - Flush overflow follows the same rules as a normal push.
- Not defined: no `flush` or `word_bytes` ports. FIFO entries are `C_WORD_W` bits.

## Structure
- Package `syn_pkg`: `C_BYTE_W`=8, lane-count typedef, FIFO pointer width function.
- Sub-module `syn_sync_fifo`: parameterized width/depth FWFT FIFO with full/empty/level. The packer instantiates one instance.

## Test plan
- N=4, bytes 0x11,0x22,0x33,0x44 on consecutive cycles, `word_rdy`=1 -> `word_data`=0x44332211 with `word_vld` one cycle after the 4th byte, held for one cycle.
- `word_rdy`=0, 20 back-to-back bytes (5 words, depth 4) -> `fifo_level`=4, 5th word dropped, `overflow`=1, first 4 words intact in order once `word_rdy`=1.
- Full FIFO, 4th byte of a word on the same edge as a pop -> no overflow, level stays 4.
- `overflow`=1, pulse `ovf_clr` -> 0. `ovf_clr` coincident with a new drop -> stays 1.
- Assert `rst_n`=0 after 2 bytes, release, send 4 bytes 0xA0..0xA3 -> word 0xA3A2A1A0, with no leftover bytes.
- FLUSH_EN: bytes 0x01,0x02 then `flush` -> `word_data`=0x00000201, `word_bytes`=2. Next 4 bytes form a full word with `word_bytes`=4.

Source files
------------

// File: rtl/syn_pkg.sv
// Shared types and helpers for the synthesis byte packer.
package syn_pkg;

  localparam int C_BYTE_W = 8;

  typedef logic [C_BYTE_W-1:0] byte_t;
  typedef logic [7:0]          lane_cnt_t;

  function automatic int ptr_w(input int depth);
    return (depth > 2) ? $clog2(depth) : 1;
  endfunction

  function automatic int lanes(input int word_w);
    return word_w / C_BYTE_W;
  endfunction

endpackage

// File: rtl/syn_sync_fifo.sv
// First-word-fall-through synchronous FIFO with full/empty/level.
module syn_sync_fifo
  import syn_pkg::*;
#(
  parameter int W = 32,
  parameter int D = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            push_i,
  input  logic [W-1:0]    din_i,
  input  logic            pop_i,
  output logic [W-1:0]    dout_o,
  output logic            full_o,
  output logic            empty_o,
  output logic [ptr_w(D):0] level_o
);

  localparam int AW = ptr_w(D);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(D);

  logic [W-1:0]  mem_q [D];
  logic [AW-1:0] wr_q;
  logic [AW-1:0] rd_q;
  logic [AW:0]   cnt_q;
  logic          push_ok;
  logic          pop_ok;

  assign full_o  = (cnt_q == FULL_CNT);
  assign empty_o = (cnt_q == '0);
  assign level_o = cnt_q;
  assign dout_o  = mem_q[rd_q];

  // a full FIFO still accepts a push when the head leaves on the same edge
  assign pop_ok  = pop_i & ~empty_o;
  assign push_ok = push_i & (~full_o | pop_ok);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < D; i++) mem_q[i] <= '0;
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (push_ok) begin
        mem_q[wr_q] <= din_i;
        wr_q        <= wr_q + 1'b1;
      end
      if (pop_ok) rd_q <= rd_q + 1'b1;
      unique case ({push_ok, pop_ok})
        2'b10:   cnt_q <= cnt_q + 1'b1;
        2'b01:   cnt_q <= cnt_q - 1'b1;
        default: cnt_q <= cnt_q;
      endcase
    end
  end

endmodule

// File: rtl/syn_byte_packer.sv
// Packs the upstream byte stream into words behind a small FWFT FIFO.
// SYN_PACKER_FLUSH_EN adds partial-word flush and a per-word byte count.
module syn_byte_packer
  import syn_pkg::*;
#(
  parameter int C_WORD_W     = 32,
  parameter int C_FIFO_DEPTH = 4
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [7:0]                  byte_data,
  input  logic                        byte_vld,
  output logic [C_WORD_W-1:0]         word_data,
  output logic                        word_vld,
  input  logic                        word_rdy,
  output logic [$clog2(C_FIFO_DEPTH):0] fifo_level,
  input  logic                        ovf_clr,
  output logic                        overflow
`ifdef SYN_PACKER_FLUSH_EN
  ,
  input  logic                        flush,
  output logic [$clog2(C_WORD_W/8):0] word_bytes
`endif
);

  localparam int N  = lanes(C_WORD_W);
  localparam int CW = $clog2(N) + 1;
  localparam logic [CW-1:0] N_CNT = CW'(N);
`ifdef SYN_PACKER_FLUSH_EN
  localparam int EW = C_WORD_W + CW;
`else
  localparam int EW = C_WORD_W;
`endif

  logic [CW-1:0]       cnt_q;
  logic [CW-1:0]       cnt_d;
  logic [CW-1:0]       fill;
  byte_t               asm_q [N-1];
  logic [C_WORD_W-1:0] word_d;
  logic [EW-1:0]       din;
  logic [EW-1:0]       dout;
  logic                push;
  logic                pop;
  logic                full;
  logic                empty;
  logic                drop;
  logic                fflush;
  logic                ovf_q;
  logic                ovf_d;

`ifdef SYN_PACKER_FLUSH_EN
  assign fflush = flush;
  assign din    = {fill, word_d};
  assign {word_bytes, word_data} = dout;
`else
  assign fflush    = 1'b0;
  assign din       = word_d;
  assign word_data = dout;
`endif

  assign fill  = cnt_q + CW'(byte_vld);
  assign push  = (fill == N_CNT) | (fflush & (fill != '0));
  assign cnt_d = push ? '0 : fill;
  assign pop   = word_vld & word_rdy;
  assign drop  = push & full & ~pop;
  assign ovf_d = drop | (ovf_q & ~ovf_clr);

  assign word_vld = ~empty;
  assign overflow = ovf_q;

  // lanes at or above the count are stale from older words and read as zero
  always_comb begin
    word_d = '0;
    for (int k = 0; k < N - 1; k++) begin
      if (CW'(k) < cnt_q) word_d[k*C_BYTE_W +: C_BYTE_W] = asm_q[k];
    end
    for (int k = 0; k < N; k++) begin
      if (byte_vld && cnt_q == CW'(k))
        word_d[k*C_BYTE_W +: C_BYTE_W] = byte_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
      ovf_q <= 1'b0;
      for (int k = 0; k < N - 1; k++) asm_q[k] <= '0;
    end else begin
      cnt_q <= cnt_d;
      ovf_q <= ovf_d;
      for (int k = 0; k < N - 1; k++) begin
        if (byte_vld && cnt_q == CW'(k)) asm_q[k] <= byte_data;
      end
    end
  end

  syn_sync_fifo #(
    .W (EW),
    .D (C_FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push_i  (push),
    .din_i   (din),
    .pop_i   (pop),
    .dout_o  (dout),
    .full_o  (full),
    .empty_o (empty),
    .level_o (fifo_level)
  );

endmodule

// File: tb/tb_syn_byte_packer.sv
// Self-checking bench for syn_byte_packer against a queue-based model.
module tb_syn_byte_packer;

  localparam int W = 32;
  localparam int D = 4;
  localparam int N = W / 8;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [7:0]    byte_data = '0;
  logic          byte_vld = 1'b0;
  logic          word_rdy = 1'b0;
  logic          ovf_clr = 1'b0;
  logic [W-1:0]  word_data;
  logic          word_vld;
  logic [2:0]    fifo_level;
  logic          overflow;
`ifdef SYN_PACKER_FLUSH_EN
  logic          flush = 1'b0;
  logic [2:0]    word_bytes;
`endif

  int n_chk = 0;
  int n_fail = 0;

  syn_byte_packer #(
    .C_WORD_W     (W),
    .C_FIFO_DEPTH (D)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .byte_data  (byte_data),
    .byte_vld   (byte_vld),
    .word_data  (word_data),
    .word_vld   (word_vld),
    .word_rdy   (word_rdy),
    .fifo_level (fifo_level),
    .ovf_clr    (ovf_clr),
    .overflow   (overflow)
`ifdef SYN_PACKER_FLUSH_EN
    ,
    .flush      (flush),
    .word_bytes (word_bytes)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // model: pending bytes of the current word, stored words, sticky flag
  logic [7:0]   part[$];
  logic [W-1:0] mq[$];
  int           mb[$];
  bit           movf = 1'b0;
  bit           m_full, m_pop, m_pw, m_drop;
  logic [W-1:0] m_w;

  always @(negedge rst_n) begin
    part.delete();
    mq.delete();
    mb.delete();
    movf = 1'b0;
  end

  always @(posedge clk) begin
    if (rst_n) begin
      m_full = (mq.size() == D);
      m_pop  = (mq.size() > 0) && word_rdy;
      if (byte_vld) part.push_back(byte_data);
      m_pw = (part.size() == N);
`ifdef SYN_PACKER_FLUSH_EN
      if (flush && part.size() > 0) m_pw = 1'b1;
`endif
      if (m_pop) begin
        void'(mq.pop_front());
        void'(mb.pop_front());
      end
      m_drop = 1'b0;
      if (m_pw) begin
        m_w = '0;
        foreach (part[k]) m_w[8*k +: 8] = part[k];
        if (!m_full || m_pop) begin
          mq.push_back(m_w);
          mb.push_back(part.size());
        end else begin
          m_drop = 1'b1;
        end
        part.delete();
      end
      if (m_drop) movf = 1'b1;
      else if (ovf_clr) movf = 1'b0;
    end
  end

  always @(negedge clk) begin
    chk("level", fifo_level, mq.size());
    chk("vld", word_vld, mq.size() > 0);
    chk("ovf", overflow, movf);
    if (mq.size() > 0) begin
      chk("data", word_data, mq[0]);
`ifdef SYN_PACKER_FLUSH_EN
      chk("bytes", word_bytes, mb[0]);
`endif
    end
  end

  task automatic drive(input logic v, input logic [7:0] b, input logic r);
    @(negedge clk);
    byte_vld  = v;
    byte_data = b;
    word_rdy  = r;
    ovf_clr   = 1'b0;
`ifdef SYN_PACKER_FLUSH_EN
    flush     = 1'b0;
`endif
  endtask

  initial begin
    repeat (2) @(negedge clk);
    chk("rst_vld", word_vld, 0);
    chk("rst_data", word_data, 0);
    chk("rst_level", fifo_level, 0);
    chk("rst_ovf", overflow, 0);
    rst_n = 1'b1;

    // single word with a ready consumer
    drive(1, 8'h11, 1);
    drive(1, 8'h22, 1);
    drive(1, 8'h33, 1);
    drive(1, 8'h44, 1);
    drive(0, 8'h00, 1);
    chk("t1_vld", word_vld, 1);
    chk("t1_word", word_data, 32'h44332211);
    chk("t1_level", fifo_level, 1);
    drive(0, 8'h00, 1);
    chk("t1_gone", word_vld, 0);

    // five words into a depth-4 FIFO
    for (int i = 0; i < 20; i++) drive(1, 8'(i), 0);
    drive(0, 8'h00, 0);
    chk("t2_level", fifo_level, 4);
    chk("t2_ovf", overflow, 1);
    chk("t2_head", word_data, 32'h03020100);
    ovf_clr = 1'b1;
    drive(0, 8'h00, 0);
    chk("t2_clr", overflow, 0);

    // completion coinciding with a pop on a full FIFO
    drive(1, 8'hB0, 0);
    drive(1, 8'hB1, 0);
    drive(1, 8'hB2, 0);
    drive(1, 8'hB3, 1);
    drive(0, 8'h00, 0);
    chk("t3_level", fifo_level, 4);
    chk("t3_ovf", overflow, 0);
    chk("t3_head", word_data, 32'h07060504);

    // clear coinciding with a fresh drop
    drive(1, 8'hC0, 0);
    drive(1, 8'hC1, 0);
    drive(1, 8'hC2, 0);
    drive(1, 8'hC3, 0);
    ovf_clr = 1'b1;
    drive(0, 8'h00, 0);
    chk("t4_ovf", overflow, 1);
    repeat (6) drive(0, 8'h00, 1);
    chk("t4_empty", fifo_level, 0);
    ovf_clr = 1'b1;
    drive(0, 8'h00, 0);

    // reset in the middle of a word
    drive(1, 8'h55, 1);
    drive(1, 8'h66, 1);
    @(posedge clk);
    #2 rst_n = 1'b0;
    @(negedge clk);
    byte_vld = 1'b0;
    chk("t5_rst_ovf", overflow, 0);
    chk("t5_rst_lvl", fifo_level, 0);
    rst_n = 1'b1;
    drive(1, 8'hA0, 1);
    drive(1, 8'hA1, 1);
    drive(1, 8'hA2, 1);
    drive(1, 8'hA3, 1);
    drive(0, 8'h00, 1);
    chk("t5_word", word_data, 32'hA3A2A1A0);
    chk("t5_vld", word_vld, 1);

`ifdef SYN_PACKER_FLUSH_EN
    drive(1, 8'h01, 0);
    drive(1, 8'h02, 0);
    drive(0, 8'h00, 0);
    flush = 1'b1;
    drive(0, 8'h00, 0);
    chk("fl_word", word_data, 32'h00000201);
    chk("fl_bytes", word_bytes, 2);
    drive(0, 8'h00, 1);
    drive(1, 8'h0A, 0);
    drive(1, 8'h0B, 0);
    drive(1, 8'h0C, 0);
    drive(1, 8'h0D, 0);
    drive(0, 8'h00, 0);
    chk("fl_full", word_data, 32'h0D0C0B0A);
    chk("fl_full_b", word_bytes, 4);
    drive(0, 8'h00, 1);
`endif

    // randomized traffic with varying consumer duty
    for (int blk = 0; blk < 6; blk++) begin
      int rp;
      rp = $urandom_range(0, 100);
      for (int c = 0; c < 500; c++) begin
        @(negedge clk);
        byte_vld  = ($urandom_range(0, 3) != 0);
        byte_data = 8'($urandom);
        word_rdy  = ($urandom_range(0, 99) < rp);
        ovf_clr   = ($urandom_range(0, 15) == 0);
`ifdef SYN_PACKER_FLUSH_EN
        flush     = ($urandom_range(0, 9) == 0);
`endif
      end
    end
    repeat (10) drive(0, 8'h00, 1);
    chk("end_empty", fifo_level, 0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
